// File: rtl/pipelined_mcc_adder.sv
// Pipelined Manchester-carry-chain adder with valid/ready stage handshake.
// Optional MCC_SUB_EN adds in_sub for a - b via operand inversion at entry.
module pipelined_mcc_adder #(
  parameter int WIDTH            = 32,
  parameter int GROUP            = 4,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef MCC_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum
);

  localparam int NGRP    = WIDTH / GROUP;
  localparam int GPS     = GROUPS_PER_STAGE;
  localparam int NSTAGES = (NGRP + GPS - 1) / GPS;
  localparam int NOPS    = (NSTAGES > 1) ? NSTAGES - 1 : 1;

  // One group: active-low carry chain, sum = P xnor _c[i-1]
  function automatic logic [GROUP:0] mcc_group(
    input logic [GROUP-1:0] a,
    input logic [GROUP-1:0] b,
    input logic             ci
  );
    logic             nc;
    logic             p;
    logic             g;
    logic [GROUP-1:0] s;
    nc = ~ci;
    s  = '0;
    for (int i = 0; i < GROUP; i++) begin
      p    = a[i] ^ b[i];
      g    = a[i] & b[i];
      s[i] = ~(p ^ nc);
      nc   = g ? 1'b0 : (p ? nc : 1'b1);
    end
    return {~nc, s};
  endfunction

  logic [NSTAGES-1:0] v;
  logic [NSTAGES-1:0] load;
  logic [NSTAGES-1:0] vi;
  logic [WIDTH-1:0]   sq    [NSTAGES];
  logic               cq    [NSTAGES];
  logic [WIDTH-1:0]   op_a  [NOPS];
  logic [WIDTH-1:0]   op_b  [NOPS];
  logic [WIDTH-1:0]   a_in  [NSTAGES];
  logic [WIDTH-1:0]   b_in  [NSTAGES];
  logic [WIDTH-1:0]   s_in  [NSTAGES];
  logic               c_in  [NSTAGES];
  logic [WIDTH-1:0]   s_nxt [NSTAGES];
  logic               c_nxt [NSTAGES];
  logic [WIDTH-1:0]   b0;
  logic               c0;
  logic               l;

`ifdef MCC_SUB_EN
  assign b0 = in_sub ? ~in_b : in_b;
  assign c0 = in_sub | in_cin;
`else
  assign b0 = in_b;
  assign c0 = in_cin;
`endif

  always_comb begin
    a_in[0] = in_a;
    b_in[0] = b0;
    c_in[0] = c0;
    s_in[0] = '0;
    vi[0]   = in_valid;
    for (int k = 1; k < NSTAGES; k++) begin
      a_in[k] = op_a[k-1];
      b_in[k] = op_b[k-1];
      c_in[k] = cq[k-1];
      s_in[k] = sq[k-1];
      vi[k]   = v[k-1];
    end
  end

  always_comb begin
    logic [GROUP:0] r;
    logic           c;
    int             gi;
    r  = '0;
    c  = 1'b0;
    gi = 0;
    for (int k = 0; k < NSTAGES; k++) begin
      c        = c_in[k];
      s_nxt[k] = s_in[k];
      for (int j = 0; j < GPS; j++) begin
        gi = k * GPS + j;
        if (gi < NGRP) begin
          r = mcc_group(a_in[k][gi*GROUP +: GROUP],
                        b_in[k][gi*GROUP +: GROUP], c);
          s_nxt[k][gi*GROUP +: GROUP] = r[GROUP-1:0];
          c = r[GROUP];
        end
      end
      c_nxt[k] = c;
    end
  end

  // Load enables ripple back from the output; empty stages always load
  always_comb begin
    load = '0;
    l    = !v[NSTAGES-1] || out_ready;
    load[NSTAGES-1] = l;
    for (int k = NSTAGES - 2; k >= 0; k--) begin
      l       = !v[k] || l;
      load[k] = l;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < NSTAGES; k++) begin
        sq[k] <= '0;
        cq[k] <= 1'b0;
      end
      for (int k = 0; k < NOPS; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (load[k]) begin
          v[k] <= vi[k];
          if (vi[k]) begin
            sq[k] <= s_nxt[k];
            cq[k] <= c_nxt[k];
            if (k < NSTAGES - 1) begin
              op_a[k] <= a_in[k];
              op_b[k] <= b_in[k];
            end
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = v[NSTAGES-1];
  assign out_sum   = {cq[NSTAGES-1], sq[NSTAGES-1]};

endmodule

// File: tb/tb_pipelined_mcc_adder.sv
// Self-checking bench for pipelined_mcc_adder: directed table, corner
// sequences and random streaming against an arithmetic reference.
module tb_pipelined_mcc_adder;

  localparam int W  = 32;
  localparam int W2 = 16;
  localparam int NRAND = 10000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W:0]    out_sum;

  logic          in_valid2 = 1'b0;
  logic          in_ready2;
  logic [W2-1:0] a2 = '0;
  logic [W2-1:0] b2 = '0;
  logic          cin2 = 1'b0;
  logic          sub2 = 1'b0;
  logic          out_valid2;
  logic          out_ready2 = 1'b1;
  logic [W2:0]   out_sum2;

  int checks = 0;
  int errors = 0;

  logic [W:0]  q  [$];
  logic [W2:0] q2 [$];
  logic        held = 1'b0;
  logic [W:0]  held_sum = '0;

  always #5 clk = ~clk;

  pipelined_mcc_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef MCC_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  // NGRP=8, three groups per stage: uneven last stage, 3 stages
  pipelined_mcc_adder #(
    .WIDTH(W2), .GROUP(2), .GROUPS_PER_STAGE(3)
  ) u2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_a      (a2),
    .in_b      (b2),
    .in_cin    (cin2),
`ifdef MCC_SUB_EN
    .in_sub    (sub2),
`endif
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_sum   (out_sum2)
  );

  function automatic logic [W:0] ref_sum(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic cin, input logic sub
  );
    if (sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b} + {32'd0, cin};
  endfunction

  task automatic chk(input string name, input logic [W:0] act,
                     input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready)
        q.push_back(ref_sum(in_a, in_b, in_cin, in_sub));
      if (held) chk("stall_hold", out_sum, held_sum);
      held     = out_valid && !out_ready;
      held_sum = out_sum;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 33'(out_valid), 33'd0);
        else chk("stream", out_sum, q.pop_front());
      end
      if (in_valid2 && in_ready2)
        q2.push_back({1'b0, a2} + {1'b0, b2} + {16'd0, cin2});
      if (out_valid2 && out_ready2) begin
        if (q2.size() == 0) chk("spurious_out2", 33'(out_valid2), 33'd0);
        else chk("stream2", 33'(out_sum2), 33'(q2.pop_front()));
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W:0] exp, input string name);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    out_ready = 1'b1;
    #1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin in_valid = 1'b0; in_sub = 1'b0; end
      #1;
      if (c < 4) chk({name, "_early"}, 33'(out_valid), 33'd0);
      else begin
        chk({name, "_valid"}, 33'(out_valid), 33'd1);
        chk(name, out_sum, exp);
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  sent;
    int  cyc;
    logic fire;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 33'h1_0000_0000};
    vecs[1] = '{32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 33'h1_0000_0000};
    vecs[2] = '{32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 33'h0_FFFF_FFFF};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out_sum", out_sum, 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 33'(in_ready), 33'd1);

    // Directed vectors with exact latency
    for (int i = 0; i < 7; i++)
      send_one(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
               vecs[i].exp, $sformatf("vec%0d", i));

    // Back-to-back 8 beats
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = (c < 8);
      in_a      = 32'(c);
      in_b      = 32'(3 * c);
      in_cin    = c[0];
      #1;
      chk("b2b_ready", 33'(in_ready), 33'd1);
      if (c >= 4) begin
        chk("b2b_valid", 33'(out_valid), 33'd1);
        chk("b2b_sum", out_sum, 33'(4 * (c - 4) + ((c - 4) & 1)));
      end else begin
        chk("b2b_fill", 33'(out_valid), 33'd0);
      end
    end

    // Stall on full pipe, then drain
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      in_valid  = (c <= 9);
      in_a      = 32'(100 + (c < 4 ? c : 4));
      in_b      = 32'(c < 4 ? c : 4);
      in_cin    = 1'b0;
      out_ready = (c >= 9);
      #1;
      if (c < 4) chk("stall_fill_ready", 33'(in_ready), 33'd1);
      else if (c < 9) begin
        chk("stall_ready", 33'(in_ready), 33'd0);
        chk("stall_valid", 33'(out_valid), 33'd1);
        chk("stall_sum", out_sum, 33'd100);
      end else begin
        if (c == 9) chk("full_consume_ready", 33'(in_ready), 33'd1);
        chk("drain_valid", 33'(out_valid), 33'd1);
        chk("drain_sum", out_sum, 33'(100 + 2 * (c - 9)));
      end
    end

    // Reset with three beats in flight
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = 32'(c + 1);
      in_b      = 32'(c + 1);
      in_cin    = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    q.delete();
    q2.delete();
    #1;
    chk("midrst_valid", 33'(out_valid), 33'd0);
    chk("midrst_sum", out_sum, 33'd0);
    chk("midrst_ready", 33'(in_ready), 33'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #2;
      chk("postrst_quiet", 33'(out_valid), 33'd0);
      chk("postrst_sum", out_sum, 33'd0);
    end
    send_one(32'd2, 32'd3, 1'b0, 1'b0, 33'd5, "after_rst");

`ifdef MCC_SUB_EN
    send_one(32'd5, 32'd7, 1'b1, 1'b1, 33'h0_FFFF_FFFE, "sub_neg");
    send_one(32'd7, 32'd5, 1'b0, 1'b1, 33'h1_0000_0002, "sub_pos");
    send_one(32'd7, 32'd5, 1'b1, 1'b0, 33'h0_0000_000D, "sub_off");
`endif

    // Random streaming with random back-pressure
    sent = 0;
    cyc  = 0;
    fire = 1'b0;
    in_valid = 1'b0;
    while ((sent < NRAND || q.size() != 0 || q2.size() != 0)
           && cyc < 60000) begin
      @(posedge clk); #1;
      if (!in_valid || fire) begin
        in_valid = (sent < NRAND) && ($urandom_range(3) != 0);
        in_a     = ($urandom_range(7) == 0) ? '1 : $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom_range(1));
`ifdef MCC_SUB_EN
        in_sub   = 1'($urandom_range(1));
`endif
      end
      out_ready = ($urandom_range(3) != 0);
      in_valid2 = (sent < NRAND) && ($urandom_range(1) == 1);
      a2        = 16'($urandom);
      b2        = 16'($urandom);
      cin2      = 1'($urandom_range(1));
      @(negedge clk);
      fire = in_valid && in_ready;
      if (fire) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    chk("rand_timeout", 33'(cyc >= 60000), 33'd0);
    chk("rand_sent", 33'(sent), 33'(NRAND));
    chk("rand_drain", 33'(q.size()), 33'd0);
    chk("rand_drain2", 33'(q2.size()), 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
